switch_cmd_router: RTL and testbench
====================================

Name: switch_cmd_router

Overview:
- Parametrised successor to the board switch front-end of the UART.
- Synchronises the raw switches, mode select and a push-button. Debounces the button.
- On each debounced press, either commits a config word or issues one write into the TX FIFO.
- Config is latched only on a press, not continuously. A write into a full FIFO is held pending until space frees.

Parameters:
- DATA_W, 8: width of the TX write word.
- CFG_W, 6: width of the UART config word (parity/stop/baud-select bits).
- SW_W, 8: number of physical switches; must be ≥ max(DATA_W, CFG_W).
- DEB_CYCLES, 16: consecutive stable synchronised samples needed to change the debounced button level; ≥ 2.
- SYNC_STAGES, 2: flip-flop stages on every asynchronous input; ≥ 2.
- CFG_RST, 0: reset value of o_config.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_switches  in  SW_W  raw switch bank (asynchronous)
- i_sel  in  1  raw mode switch: 0 = config, 1 = data (asynchronous)
- i_btn  in  1  raw push-button, active high, bouncy (asynchronous)
- i_fifo_full  in  1  TX FIFO full flag (synchronous to i_clk)
- o_wr_data  out  DATA_W  registered write word, held between writes
- o_wr_en  out  1  one-cycle FIFO write strobe
- o_config  out  CFG_W  registered config word
- o_cfg_upd  out  1  one-cycle pulse after o_config changes
- o_busy  out  1  high while a write is pending on a full FIFO
- o_drop  out  1  one-cycle pulse when a press is discarded

Behaviour:
- Reset (async assert, sync release):
  - all synchronisers, debounce counter and debounced level → 0
  - o_wr_data → 0, o_config → CFG_RST
  - o_wr_en, o_cfg_upd, o_busy, o_drop → 0
  - FSM → IDLE
- Reset mid-operation aborts any pending write; no strobe is issued after release.
- Synchronisation: i_switches, i_sel and i_btn each pass SYNC_STAGES flops. Call the results sw_s, sel_s, btn_s.
- Debounce:
  - The counter increments each cycle btn_s differs from the debounced level.
  - Any cycle where they are equal clears it to 0.
  - When the counter reaches DEB_CYCLES-1 and btn_s still differs, the level flips on that clock edge and the counter clears.
  - Pulses shorter than DEB_CYCLES samples are ignored.
- Press event: the debounced level goes 0→1, one cycle wide. The release edge generates nothing.
- FSM IDLE, on press:
  - sel_s = 0: o_config ← sw_s[CFG_W-1:0] on the same edge; o_cfg_upd = 1 the following cycle; stay IDLE.
  - sel_s = 1: o_wr_data ← sw_s[DATA_W-1:0].
    - If i_fifo_full = 0 in the press cycle: o_wr_en = 1 the next cycle; stay IDLE.
    - Otherwise go WAIT; o_busy = 1 from the next cycle.
- FSM WAIT:
  - Each cycle i_fifo_full = 0: o_wr_en = 1 the next cycle, o_busy drops on that same edge, return to IDLE.
  - o_wr_data holds throughout.
  - A press while in WAIT is discarded: o_drop = 1 for one cycle; o_config and o_wr_data unchanged.
- A press in the cycle WAIT exits is treated as a WAIT press and dropped.
- Strobe rules:
  - o_wr_en is never high for two consecutive cycles.
  - o_wr_en and o_cfg_upd are never high together.
  - o_wr_data is stable in the cycle o_wr_en is high.
- Switch changes without a press never alter any output.
- Latency, raw button held high to o_wr_en: SYNC_STAGES + DEB_CYCLES + 1 cycles (FIFO not full).

Test Plan:
- Reset, no stimulus → o_config = CFG_RST, o_wr_data = 0, all strobes 0 for 100 cycles; toggle i_switches → no output change.
- i_sel = 0, switches = 8'h2D, clean press held 40 cycles → o_config = 6'h2D exactly once; o_cfg_upd one cycle; o_wr_en never asserts.
- i_sel = 1, switches = 8'hA5, FIFO not full, press (DEB_CYCLES = 16, SYNC_STAGES = 2) → o_wr_en single pulse 19 cycles after i_btn rise, with o_wr_data = 8'hA5. Release after 50 cycles → no second pulse.
- Bounce: i_btn toggles every 3 cycles for 60 cycles, then holds high → exactly one o_wr_en; bursts of 15-cycle highs alone → no strobe.
- i_fifo_full = 1, press with switches = 8'h3C → o_busy rises, o_wr_en stays 0. A second press → o_drop one cycle, o_wr_data still 8'h3C. Deassert full → o_wr_en one cycle next clock, o_busy falls the same edge.
- In WAIT, assert i_rst_n = 0 for 2 cycles and release with full = 0 → no o_wr_en; o_busy = 0; o_wr_data = 0.

Source files
------------

// File: rtl/switch_cmd_router.sv
// Board switch front-end: synchronises switches/mode/button, debounces the button,
// and on each press either commits a config word or issues one TX FIFO write.
module switch_cmd_router #(
    parameter int unsigned      DATA_W      = 8,
    parameter int unsigned      CFG_W       = 6,
    parameter int unsigned      SW_W        = 8,
    parameter int unsigned      DEB_CYCLES  = 16,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [CFG_W-1:0] CFG_RST     = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [SW_W-1:0]   i_switches,
    input  logic              i_sel,
    input  logic              i_btn,
    input  logic              i_fifo_full,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_wr_en,
    output logic [CFG_W-1:0]  o_config,
    output logic              o_cfg_upd,
    output logic              o_busy,
    output logic              o_drop
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    logic [SYNC_STAGES-1:0][SW_W-1:0] sw_sync_q, sw_sync_d;
    logic [SYNC_STAGES-1:0]           sel_sync_q, sel_sync_d;
    logic [SYNC_STAGES-1:0]           btn_sync_q, btn_sync_d;
    logic [SW_W-1:0]                  sw_s;
    logic                             sel_s, btn_s;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              deb_q, deb_d;
    logic              press_q, press_d;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic [CFG_W-1:0]  config_q, config_d;
    logic              cfg_upd_q, cfg_upd_d;
    logic              busy_q, busy_d;
    logic              drop_q, drop_d;

    assign sw_s  = sw_sync_q[SYNC_STAGES-1];
    assign sel_s = sel_sync_q[SYNC_STAGES-1];
    assign btn_s = btn_sync_q[SYNC_STAGES-1];

    always_comb begin
        sw_sync_d  = {sw_sync_q[SYNC_STAGES-2:0], i_switches};
        sel_sync_d = {sel_sync_q[SYNC_STAGES-2:0], i_sel};
        btn_sync_d = {btn_sync_q[SYNC_STAGES-2:0], i_btn};

        // Level flips only after DEB_CYCLES consecutive differing samples.
        deb_d = deb_q;
        cnt_d = '0;
        if (btn_s != deb_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = deb_d & ~deb_q;

        state_d   = state_q;
        wr_data_d = wr_data_q;
        config_d  = config_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        cfg_upd_d = 1'b0;
        drop_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (press_q) begin
                    if (!sel_s) begin
                        config_d  = sw_s[CFG_W-1:0];
                        cfg_upd_d = 1'b1;
                    end else begin
                        wr_data_d = sw_s[DATA_W-1:0];
                        if (!i_fifo_full) begin
                            wr_en_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                            busy_d  = 1'b1;
                        end
                    end
                end
            end
            ST_WAIT: begin
                // A press here is dropped even on the cycle the write drains.
                drop_d = press_q;
                if (!i_fifo_full) begin
                    wr_en_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sw_sync_q  <= '0;
            sel_sync_q <= '0;
            btn_sync_q <= '0;
            cnt_q      <= '0;
            deb_q      <= 1'b0;
            press_q    <= 1'b0;
            state_q    <= ST_IDLE;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            config_q   <= CFG_RST;
            cfg_upd_q  <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            sw_sync_q  <= sw_sync_d;
            sel_sync_q <= sel_sync_d;
            btn_sync_q <= btn_sync_d;
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            press_q    <= press_d;
            state_q    <= state_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            config_q   <= config_d;
            cfg_upd_q  <= cfg_upd_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
        end
    end

    assign o_wr_data = wr_data_q;
    assign o_wr_en   = wr_en_q;
    assign o_config  = config_q;
    assign o_cfg_upd = cfg_upd_q;
    assign o_busy    = busy_q;
    assign o_drop    = drop_q;

endmodule

// File: tb/tb_switch_cmd_router.sv
// Directed bench for switch_cmd_router: config commit, write latency, debounce,
// full-FIFO pending/drop behaviour and reset abort.
module tb_switch_cmd_router;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] switches;
    logic       sel, btn, fifo_full;
    logic [7:0] wr_data;
    logic       wr_en;
    logic [5:0] cfg;
    logic       cfg_upd, busy, drop;

    switch_cmd_router #(
        .DATA_W(8), .CFG_W(6), .SW_W(8), .DEB_CYCLES(16), .SYNC_STAGES(2), .CFG_RST(6'h15)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_switches(switches), .i_sel(sel), .i_btn(btn),
        .i_fifo_full(fifo_full), .o_wr_data(wr_data), .o_wr_en(wr_en), .o_config(cfg),
        .o_cfg_upd(cfg_upd), .o_busy(busy), .o_drop(drop)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_wr = 0, n_cfg = 0, n_drop = 0, n_viol = 0, last_wr_cyc = 0;
    logic [7:0]  last_wr_data = '0;
    logic        prev_wr = 1'b0;

    always @(negedge clk) begin
        if (wr_en) begin
            n_wr++;
            last_wr_data = wr_data;
            last_wr_cyc  = cyc;
            if (prev_wr) n_viol++;
        end
        if (wr_en && cfg_upd) n_viol++;
        if (cfg_upd) n_cfg++;
        if (drop) n_drop++;
        prev_wr = wr_en;
    end

    int unsigned n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int unsigned hi, input int unsigned lo);
        btn = 1'b1;
        tick(hi);
        btn = 1'b0;
        tick(lo);
    endtask

    int unsigned base_wr, base_cfg, base_drop, c0;

    initial begin
        rst_n = 1'b0; switches = '0; sel = 1'b0; btn = 1'b0; fifo_full = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("rst_config", cfg, 6'h15);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_strobes", {wr_en, cfg_upd, busy, drop}, 4'b0000);

        // Idle with switch activity only
        for (int i = 0; i < 100; i++) begin
            switches = 8'($urandom);
            sel      = 1'($urandom);
            tick(1);
        end
        chk("idle_wr_cnt", n_wr, 0);
        chk("idle_cfg_cnt", n_cfg, 0);
        chk("idle_drop_cnt", n_drop, 0);
        chk("idle_outputs", {wr_data, 2'b00, cfg, busy}, {8'h00, 2'b00, 6'h15, 1'b0});

        // Config commit
        sel = 1'b0; switches = 8'h2D;
        tick(5);
        press(40, 40);
        chk("cfg_value", cfg, 6'h2D);
        chk("cfg_upd_cnt", n_cfg, 1);
        chk("cfg_no_wr", n_wr, 0);

        // Data write latency
        sel = 1'b1; switches = 8'hA5;
        tick(5);
        base_wr = n_wr;
        c0 = cyc;
        btn = 1'b1;
        tick(50);
        btn = 1'b0;
        tick(40);
        chk("wr_cnt", n_wr - base_wr, 1);
        chk("wr_latency", last_wr_cyc - c0, 19);
        chk("wr_data", last_wr_data, 8'hA5);
        chk("wr_cfg_unchanged", cfg, 6'h2D);

        // Bounce then stable hold
        switches = 8'h5A;
        tick(5);
        base_wr = n_wr;
        for (int i = 0; i < 20; i++) begin
            btn = ~btn;
            tick(3);
        end
        btn = 1'b1;
        tick(40);
        btn = 1'b0;
        tick(40);
        chk("bounce_wr_cnt", n_wr - base_wr, 1);
        chk("bounce_wr_data", last_wr_data, 8'h5A);

        // 15-sample bursts are below threshold
        base_wr = n_wr;
        for (int i = 0; i < 4; i++) press(15, 15);
        tick(20);
        chk("burst15_wr_cnt", n_wr - base_wr, 0);

        // 16-sample burst is exactly at threshold
        switches = 8'hC3;
        tick(5);
        base_wr = n_wr;
        press(16, 40);
        chk("burst16_wr_cnt", n_wr - base_wr, 1);
        chk("burst16_wr_data", last_wr_data, 8'hC3);

        // Full FIFO: pending write, then a dropped press
        fifo_full = 1'b1; switches = 8'h3C;
        tick(5);
        base_wr = n_wr; base_drop = n_drop; base_cfg = n_cfg;
        press(25, 30);
        chk("full_busy", busy, 1'b1);
        chk("full_no_wr", n_wr - base_wr, 0);
        chk("full_wr_data", wr_data, 8'h3C);
        switches = 8'h77;
        tick(5);
        press(25, 30);
        chk("drop_cnt", n_drop - base_drop, 1);
        chk("drop_wr_data", wr_data, 8'h3C);
        chk("drop_cfg", cfg, 6'h2D);
        chk("drop_still_busy", busy, 1'b1);
        chk("drop_no_wr", n_wr - base_wr, 0);
        fifo_full = 1'b0;
        tick(1);
        chk("drain_wr_en", wr_en, 1'b1);
        chk("drain_busy", busy, 1'b0);
        chk("drain_wr_data", wr_data, 8'h3C);
        tick(1);
        chk("drain_wr_en_low", wr_en, 1'b0);
        chk("drain_no_cfg", n_cfg - base_cfg, 0);

        // Reset while a write is pending
        fifo_full = 1'b1; switches = 8'h99;
        tick(5);
        press(25, 30);
        chk("rstwait_busy", busy, 1'b1);
        chk("rstwait_data", wr_data, 8'h99);
        base_wr = n_wr;
        rst_n = 1'b0;
        tick(2);
        fifo_full = 1'b0;
        rst_n = 1'b1;
        tick(20);
        chk("rstwait_no_wr", n_wr - base_wr, 0);
        chk("rstwait_busy_low", busy, 1'b0);
        chk("rstwait_wr_data", wr_data, 8'h00);
        chk("rstwait_config", cfg, 6'h15);

        chk("strobe_rules", n_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
